// File: rtl/im_loader_if.sv
// rtl/im_loader_if.sv - loader bus: UART byte input, CPU fetch address, instruction-memory write port, status
interface im_loader_if #(
  parameter int ADDR_W = 16
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic [ADDR_W-1:0] cpu_pc;
  logic [ADDR_W-1:0] im_addr;
  logic              im_we;
  logic [31:0]       im_wdata;
  logic              cpu_hold;
  logic              done;
  logic              err;

  modport master (
    output rx_valid, rx_data, cpu_pc,
    input  im_addr, im_we, im_wdata, cpu_hold, done, err
  );

  modport slave (
    input  rx_valid, rx_data, cpu_pc,
    output im_addr, im_we, im_wdata, cpu_hold, done, err
  );
endinterface

// File: rtl/im_loader.sv
// rtl/im_loader.sv - UART image loader into instruction memory, then hands the fetch port to the CPU.
// Optional IM_LOADER_RELOAD_EN: byte 0xA5 received while running restarts loading.
module im_loader #(
  parameter int MAX_WORDS = 64,
  parameter int ADDR_W    = 16
) (
  input logic       clk,
  input logic       rst,
  im_loader_if.slave bus
);

  localparam int KW = $clog2(MAX_WORDS + 1);

  typedef enum logic [2:0] {
    LEN_LO,
    LEN_HI,
    LOAD,
    RUN,
    ERROR
  } state_e;

  state_e         state_q, state_d;
  logic [15:0]    n_q, n_d;
  logic [KW-1:0]  k_q, k_d;
  logic [1:0]     bc_q, bc_d;
  logic [23:0]    asm_q, asm_d;
  logic [31:0]    wdata_q, wdata_d;
  logic           we_q, we_d;

  logic [15:0]       n_full;
  logic              last_word;
  logic              accept;
  logic [ADDR_W-1:0] loader_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LEN_LO;
      n_q     <= '0;
      k_q     <= '0;
      bc_q    <= '0;
      asm_q   <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      k_q     <= k_d;
      bc_q    <= bc_d;
      asm_q   <= asm_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
    end
  end

  assign n_full    = {bus.rx_data, n_q[7:0]};
  assign last_word = (16'(k_q) == (n_q - 16'd1));

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    k_d     = k_q;
    bc_d    = bc_q;
    asm_d   = asm_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    accept  = 1'b0;

    case (state_q)
      LEN_LO: begin
        if (bus.rx_valid) begin
          n_d     = {8'h00, bus.rx_data};
          state_d = LEN_HI;
        end
      end

      LEN_HI: begin
        if (bus.rx_valid) begin
          n_d = n_full;
          if (n_full == 16'd0) begin
            state_d = RUN;
          end else if (32'(n_full) > MAX_WORDS) begin
            state_d = ERROR;
          end else begin
            state_d = LOAD;
            k_d     = '0;
            bc_d    = '0;
          end
        end
      end

      LOAD: begin
        accept = bus.rx_valid;
        // The write cycle still accepts the next word's lane 0, except after the final word.
        if (we_q) begin
          k_d = k_q + KW'(1);
          if (last_word) begin
            state_d = RUN;
            accept  = 1'b0;
          end
        end
        if (accept) begin
          case (bc_q)
            2'd0: asm_d[7:0]   = bus.rx_data;
            2'd1: asm_d[15:8]  = bus.rx_data;
            2'd2: asm_d[23:16] = bus.rx_data;
            default: begin
              wdata_d = {bus.rx_data, asm_q};
              we_d    = 1'b1;
            end
          endcase
          bc_d = bc_q + 2'd1;
        end
      end

      RUN: begin
`ifdef IM_LOADER_RELOAD_EN
        if (bus.rx_valid && (bus.rx_data == 8'hA5)) begin
          state_d = LEN_LO;
          n_d     = '0;
          k_d     = '0;
          bc_d    = '0;
          asm_d   = '0;
        end
`endif
      end

      ERROR: begin
      end

      default: state_d = LEN_LO;
    endcase
  end

  assign loader_addr = ADDR_W'({k_q, 2'b00});

  always_comb begin
    bus.im_addr  = (state_q == RUN) ? bus.cpu_pc : loader_addr;
    bus.im_we    = we_q && (state_q == LOAD);
    bus.im_wdata = wdata_q;
    bus.cpu_hold = (state_q != RUN);
    bus.done     = (state_q == RUN);
    bus.err      = (state_q == ERROR);
  end

endmodule

// File: tb/tb_im_loader.sv
// tb/tb_im_loader.sv - randomized self-checking bench for im_loader against a word-list model of the image.
module tb_im_loader;
  localparam int MAX_WORDS = 64;
  localparam int ADDR_W    = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  im_loader_if #(.ADDR_W(ADDR_W)) bus ();

  im_loader #(.MAX_WORDS(MAX_WORDS), .ADDR_W(ADDR_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [ADDR_W-1:0] obs_addr[$];
  logic [31:0]       obs_data[$];
  int                bad_we = 0;

  always @(negedge clk) begin
    if (bus.im_we === 1'b1) begin
      obs_addr.push_back(bus.im_addr);
      obs_data.push_back(bus.im_wdata);
      if (bus.done !== 1'b0 || bus.err !== 1'b0) bad_we++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs;
    obs_addr.delete();
    obs_data.delete();
    bad_we = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gapmax);
    int g;
    g = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
    repeat (g) tick;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    tick;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'($urandom);
  endtask

  task automatic do_reset;
    rst          = 1'b1;
    bus.rx_valid = 1'b0;
    repeat (2) tick;
    rst = 1'b0;
    clear_obs();
  endtask

  task automatic send_len(input int n, input int gapmax);
    logic [15:0] n16;
    n16 = 16'(n);
    send_byte(n16[7:0], gapmax);
    send_byte(n16[15:8], gapmax);
  endtask

  task automatic send_words(input logic [31:0] words[$], input int first, input int count, input int gapmax);
    logic [31:0] w;
    for (int i = first; i < first + count; i++) begin
      w = words[i];
      for (int j = 0; j < 4; j++) send_byte(w[8*j +: 8], gapmax);
    end
  endtask

  task automatic rand_words(input int n, output logic [31:0] words[$]);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back($urandom);
  endtask

  // Model: word i of the image lands at byte address 4*i, bytes little-endian.
  task automatic load_and_check(input string name, input logic [31:0] words[$], input int gapmax);
    bit ok;
    int n;
    n = words.size();
    send_len(n, gapmax);
    send_words(words, 0, n, gapmax);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick;
    end
    total_cnt++;
    if (ok !== 1'b1) $display("FAIL %s_done_timeout got=%0b want=1", name, ok);
    else pass_cnt++;
    total_cnt++;
    if (obs_addr.size() !== n) $display("FAIL %s_write_count got=%0d want=%0d", name, obs_addr.size(), n);
    else pass_cnt++;
    for (int i = 0; i < n && i < obs_addr.size(); i++) begin
      total_cnt++;
      if (obs_addr[i] !== ADDR_W'(4 * i) || obs_data[i] !== words[i])
        $display("FAIL %s_word%0d got=%h@%h want=%h@%h", name, i, obs_data[i], obs_addr[i], words[i], ADDR_W'(4 * i));
      else pass_cnt++;
    end
    total_cnt++;
    if (bad_we !== 0 || bus.cpu_hold !== 1'b0 || bus.err !== 1'b0)
      $display("FAIL %s_run_status got=bad_we:%0d hold:%b err:%b want=0/0/0", name, bad_we, bus.cpu_hold, bus.err);
    else pass_cnt++;
  endtask

  task automatic test_reset;
    rst          = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h05;
    bus.cpu_pc   = 16'h1234;
    repeat (3) tick;
    total_cnt++;
    if ({bus.cpu_hold, bus.done, bus.err, bus.im_we} !== 4'b1000 || bus.im_wdata !== 32'h0 || bus.im_addr !== '0)
      $display("FAIL reset_outputs got=h%b d%b e%b we%b wd=%h a=%h want=1/0/0/0 0 0",
               bus.cpu_hold, bus.done, bus.err, bus.im_we, bus.im_wdata, bus.im_addr);
    else pass_cnt++;
    bus.rx_valid = 1'b0;
    rst = 1'b0;
    clear_obs();
    // With reset dominating the strobe, a fresh 00 00 must still be parsed from LEN_LO.
    send_len(0, 0);
    total_cnt++;
    if (bus.done !== 1'b1) $display("FAIL reset_priority got=done:%b want=1", bus.done);
    else pass_cnt++;
  endtask

  task automatic test_spec_vector;
    logic [31:0] w[$];
    do_reset();
    w = '{32'h40000593, 32'h40058593};
    load_and_check("spec_vector", w, 0);
    total_cnt++;
    if (bus.done !== 1'b1) $display("FAIL spec_vector_done got=%b want=1", bus.done);
    else pass_cnt++;
  endtask

  task automatic test_zero_len;
    do_reset();
    send_len(0, 2);
    total_cnt++;
    if (bus.done !== 1'b1 || bus.cpu_hold !== 1'b0) $display("FAIL zero_len_run got=done:%b hold:%b want=1/0", bus.done, bus.cpu_hold);
    else pass_cnt++;
    repeat (3) tick;
    total_cnt++;
    if (obs_addr.size() !== 0) $display("FAIL zero_len_writes got=%0d want=0", obs_addr.size());
    else pass_cnt++;
  endtask

  task automatic test_error(input int n);
    do_reset();
    send_len(n, 1);
    total_cnt++;
    if ({bus.err, bus.cpu_hold, bus.done} !== 3'b110)
      $display("FAIL error_enter_n%0d got=e%b h%b d%b want=1/1/0", n, bus.err, bus.cpu_hold, bus.done);
    else pass_cnt++;
    for (int i = 0; i < 12; i++) send_byte(8'($urandom), 1);
    send_byte(8'hA5, 0);
    tick;
    total_cnt++;
    if (obs_addr.size() !== 0 || bus.err !== 1'b1)
      $display("FAIL error_sticky_n%0d got=writes:%0d err:%b want=0/1", n, obs_addr.size(), bus.err);
    else pass_cnt++;
    do_reset();
    total_cnt++;
    if (bus.err !== 1'b0 || bus.cpu_hold !== 1'b1) $display("FAIL error_clear got=e%b h%b want=0/1", bus.err, bus.cpu_hold);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    logic [31:0] w[$];
    do_reset();
    rand_words(3, w);
    load_and_check("back_to_back", w, 0);
  endtask

  task automatic test_random_images;
    logic [31:0] w[$];
    for (int t = 0; t < 6; t++) begin
      do_reset();
      rand_words(int'($urandom_range(8, 1)), w);
      load_and_check($sformatf("random%0d", t), w, 3);
    end
    do_reset();
    rand_words(MAX_WORDS, w);
    load_and_check("max_words", w, 0);
  endtask

  task automatic test_reset_mid_load;
    logic [31:0] w[$];
    do_reset();
    rand_words(3, w);
    send_len(3, 0);
    send_words(w, 0, 1, 1);
    send_byte(w[1][7:0], 0);
    send_byte(w[1][15:8], 0);
    rst = 1'b1;
    tick;
    total_cnt++;
    if (obs_addr.size() !== 1 || bus.im_we !== 1'b0 || bus.cpu_hold !== 1'b1 || bus.im_addr !== '0)
      $display("FAIL mid_load_reset got=writes:%0d we:%b hold:%b a=%h want=1/0/1/0",
               obs_addr.size(), bus.im_we, bus.cpu_hold, bus.im_addr);
    else pass_cnt++;
    rst = 1'b0;
    tick;
    clear_obs();
    rand_words(3, w);
    load_and_check("after_mid_reset", w, 2);
  endtask

  task automatic test_run_fetch;
    logic [31:0] w[$];
    logic [ADDR_W-1:0] pc;
    do_reset();
    rand_words(2, w);
    load_and_check("fetch_setup", w, 1);
    bus.cpu_pc = 16'h0010;
    #1;
    total_cnt++;
    if (bus.im_addr !== 16'h0010) $display("FAIL fetch_pc10 got=%h want=0010", bus.im_addr);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      pc = ADDR_W'($urandom) & ~ADDR_W'(3);
      bus.cpu_pc = pc;
      #1;
      total_cnt++;
      if (bus.im_addr !== pc) $display("FAIL fetch_rand got=%h want=%h", bus.im_addr, pc);
      else pass_cnt++;
    end
    send_byte(8'h5A, 0);
    total_cnt++;
    if (bus.done !== 1'b1 || bus.cpu_hold !== 1'b0) $display("FAIL run_other_byte got=d%b h%b want=1/0", bus.done, bus.cpu_hold);
    else pass_cnt++;
    send_byte(8'hA5, 0);
`ifdef IM_LOADER_RELOAD_EN
    total_cnt++;
    if (bus.cpu_hold !== 1'b1 || bus.done !== 1'b0 || bus.im_addr !== '0)
      $display("FAIL reload_a5 got=h%b d%b a=%h want=1/0/0", bus.cpu_hold, bus.done, bus.im_addr);
    else pass_cnt++;
    clear_obs();
    rand_words(2, w);
    load_and_check("reload_image", w, 1);
`else
    total_cnt++;
    if (bus.cpu_hold !== 1'b0 || bus.done !== 1'b1) $display("FAIL run_a5_ignored got=h%b d%b want=0/1", bus.cpu_hold, bus.done);
    else pass_cnt++;
`endif
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.cpu_pc   = '0;
    test_reset();
    test_spec_vector();
    test_zero_len();
    test_error(65);
    test_error(256);
    test_back_to_back();
    test_random_images();
    test_reset_mid_load();
    test_run_fetch();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end
endmodule
